regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between N writeback requesters
//  (ALU, load unit, CSR/mul, ...) using round-robin arbitration with valid/ready handshakes.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_wb_arbiter_rr.sv | 31 +++
 rtl/regfile_wb_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback arbiter: address width,
// default data width, the x0 encoding and the requester index assignments.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  localparam int unsigned WB_LOAD = 0;
  localparam int unsigned WB_ALU  = 1;
  localparam int unsigned WB_CSR  = 2;

  // Round-robin successor of idx among n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin search: first valid request at or after i_ptr,
// wrapping modulo N. Holds no state.
module rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_any
);

  int unsigned idx;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    idx         = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(i_ptr) + off) % N;
      if (!o_any && i_req[IDX_W'(idx)]) begin
        o_any                 = 1'b1;
        o_grant[IDX_W'(idx)]  = 1'b1;
        o_grant_idx           = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port among N_REQ writeback
// sources. Optional macro WB_ARB_LOAD_PRIO_EN gives requester 0 fixed priority.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter  int unsigned N_REQ = 3,
  parameter  int unsigned XLEN  = XLEN_DEFAULT,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        i_reset_n,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ*REG_ADDR_W-1:0] i_req_addr,
  input  logic [N_REQ*XLEN-1:0]       i_req_data,
  output logic [N_REQ-1:0]            o_req_ready,
  input  logic                        i_hold,
  output logic [REG_ADDR_W-1:0]       o_wr_addr,
  output logic [XLEN-1:0]             o_wr_data,
  output logic                        o_reg_write,
  output logic [IDX_W-1:0]            o_grant_id,
  output logic [CNT_W-1:0]            o_conflict_cnt
);

  logic [N_REQ-1:0]      rr_grant_c;
  logic [IDX_W-1:0]      rr_idx_c;
  logic                  rr_any_c;
  logic [N_REQ-1:0]      grant_c;
  logic [IDX_W-1:0]      win_idx_c;
  logic                  win_any_c;
  logic                  xfer_c;

  logic [IDX_W-1:0]      rr_ptr_q,   rr_ptr_d;
  logic [REG_ADDR_W-1:0] wr_addr_q,  wr_addr_d;
  logic [XLEN-1:0]       wr_data_q,  wr_data_d;
  logic [IDX_W-1:0]      grant_id_q, grant_id_d;
  logic                  reg_write_q, reg_write_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;

  rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr (
    .i_req       (i_req_valid),
    .i_ptr       (rr_ptr_q),
    .o_grant     (rr_grant_c),
    .o_grant_idx (rr_idx_c),
    .o_any       (rr_any_c)
  );

  // Winner selection; the load unit may override the round-robin result.
  always_comb begin
    grant_c   = rr_grant_c;
    win_idx_c = rr_idx_c;
    win_any_c = rr_any_c;
`ifdef WB_ARB_LOAD_PRIO_EN
    if (i_req_valid[WB_LOAD]) begin
      grant_c   = N_REQ'(1) << WB_LOAD;
      win_idx_c = IDX_W'(WB_LOAD);
      win_any_c = 1'b1;
    end
`endif
    xfer_c      = win_any_c && !i_hold && i_reset_n;
    o_req_ready = xfer_c ? grant_c : '0;
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    grant_id_d  = grant_id_q;
    reg_write_d = 1'b0;
    cnt_d       = cnt_q;
    if (xfer_c) begin
      wr_addr_d   = i_req_addr[REG_ADDR_W*win_idx_c +: REG_ADDR_W];
      wr_data_d   = i_req_data[XLEN*win_idx_c +: XLEN];
      grant_id_d  = win_idx_c;
      reg_write_d = (wr_addr_d != REG_ZERO);
      rr_ptr_d    = IDX_W'(rr_next(32'(win_idx_c), N_REQ));
`ifdef WB_ARB_LOAD_PRIO_EN
      if (win_idx_c == IDX_W'(WB_LOAD)) rr_ptr_d = rr_ptr_q;
`endif
    end
    // Contention is sampled only while the pipeline is not stalled.
    if (!i_hold && ($countones(i_req_valid) >= 2) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rr_ptr_q    <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      grant_id_q  <= '0;
      reg_write_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      grant_id_q  <= grant_id_d;
      reg_write_q <= reg_write_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_wr_addr      = wr_addr_q;
  assign o_wr_data      = wr_data_q;
  assign o_grant_id     = grant_id_q;
  assign o_reg_write    = reg_write_q;
  assign o_conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a behavioural model predicts grants
// and registered writes; a negedge monitor pops and compares them.
module tb_regfile_wb_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned XL = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned IW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*5-1:0]  req_addr;
  logic [N*XL-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            hold;
  logic [4:0]      wr_addr;
  logic [XL-1:0]   wr_data;
  logic            reg_write;
  logic [IW-1:0]   grant_id;
  logic [CW-1:0]   conflict_cnt;

  regfile_wb_arbiter #(.N_REQ(N), .XLEN(XL), .CNT_W(CW)) dut (
    .clk            (clk),
    .i_reset_n      (rst_n),
    .i_req_valid    (req_valid),
    .i_req_addr     (req_addr),
    .i_req_data     (req_data),
    .o_req_ready    (req_ready),
    .i_hold         (hold),
    .o_wr_addr      (wr_addr),
    .o_wr_data      (wr_data),
    .o_reg_write    (reg_write),
    .o_grant_id     (grant_id),
    .o_conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    int          id;
    int          cnt;
  } out_t;

  out_t         out_q[$];
  logic [N-1:0] rdy_q[$];
  int           total = 0;
  int           bad   = 0;
  bit           mon_en = 1'b0;

  // Reference model state
  int          m_ptr, m_cnt, m_id;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          pend[N];
  bit          v[N];
  logic [4:0]  a[N];
  logic [31:0] d[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    out_t o;
    m_ptr = 0; m_cnt = 0; m_id = 0; m_addr = '0; m_data = '0;
    for (int k = 0; k < N; k++) pend[k] = 1'b0;
    out_q.delete();
    rdy_q.delete();
    o.we = 1'b0; o.addr = '0; o.data = '0; o.id = 0; o.cnt = 0;
    out_q.push_back(o);
  endfunction

  // Requesters waiting for a grant keep their request unchanged.
  task automatic req(input int k, input bit valid, input logic [4:0] addr, input logic [31:0] data);
    if (!pend[k]) begin
      v[k] = valid; a[k] = addr; d[k] = data;
    end
  endtask

  task automatic rand_reqs(input int pct);
    for (int k = 0; k < N; k++)
      req(k, $urandom_range(0, 99) < pct, 5'($urandom_range(0, 31)), $urandom);
  endtask

  // Drive one cycle, predict its grant and the registered result, then advance.
  task automatic cycle(input bit h);
    int w;
    int nv;
    out_t o;
    w = -1;
    nv = 0;
    hold = h;
    for (int k = 0; k < N; k++) begin
      req_valid[k]       = v[k];
      req_addr[5*k +: 5] = a[k];
      req_data[XL*k +: XL] = d[k];
      nv += int'(v[k]);
    end
    if (!h) begin
`ifdef WB_ARB_LOAD_PRIO_EN
      if (v[0]) w = 0;
`endif
      if (w < 0) begin
        for (int off = 0; off < N; off++) begin
          if (v[(m_ptr + off) % N]) begin
            w = (m_ptr + off) % N;
            break;
          end
        end
      end
    end
    rdy_q.push_back((w >= 0) ? N'(1) << w : N'(0));
    if (!h && nv >= 2 && m_cnt < CNT_MAX) m_cnt++;
    o.we = 1'b0;
    if (w >= 0) begin
      o.we   = (a[w] != 5'd0);
      m_addr = a[w];
      m_data = d[w];
      m_id   = w;
`ifdef WB_ARB_LOAD_PRIO_EN
      if (w != 0) m_ptr = (w + 1) % N;
`else
      m_ptr = (w + 1) % N;
`endif
    end
    for (int k = 0; k < N; k++) pend[k] = v[k] && (k != w);
    o.addr = m_addr; o.data = m_data; o.id = m_id; o.cnt = m_cnt;
    out_q.push_back(o);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) begin
      if (!(pend[0] || pend[1] || pend[2])) break;
      for (int k = 0; k < N; k++) req(k, 1'b0, 5'd0, 32'd0);
      cycle(1'b0);
    end
    for (int k = 0; k < N; k++) req(k, 1'b0, 5'd0, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (rdy_q.size() == 0 || out_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty: rdy=%0d out=%0d at %0t", rdy_q.size(), out_q.size(), $time);
      end else begin
        logic [N-1:0] r;
        out_t o;
        r = rdy_q.pop_front();
        o = out_q.pop_front();
        check("ready", 64'(req_ready), 64'(r));
        check("reg_write", 64'(reg_write), 64'(o.we));
        check("wr_addr", 64'(wr_addr), 64'(o.addr));
        check("wr_data", 64'(wr_data), 64'(o.data));
        check("grant_id", 64'(grant_id), 64'(o.id));
        check("conflict_cnt", 64'(conflict_cnt), 64'(o.cnt));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    hold = 1'b0;
    req_valid = '1;
    req_addr = '0;
    req_data = '0;
    for (int k = 0; k < N; k++) begin
      v[k] = 1'b0; a[k] = '0; d[k] = '0; pend[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_reg_write", 64'(reg_write), 64'd0);
    check("rst_cnt", 64'(conflict_cnt), 64'd0);
    check("rst_addr", 64'(wr_addr), 64'd0);

    // Release with all requesters valid: x1,x2,x3,x1,...
    model_reset();
    for (int k = 0; k < N; k++) req(k, 1'b1, 5'(k + 1), $urandom);
    rst_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < N; k++) req(k, 1'b1, 5'(k + 1), $urandom);
      cycle(1'b0);
    end
    drain();

    // x0 write is accepted but not written
    req(1, 1'b1, 5'd0, 32'hDEADBEEF);
    cycle(1'b0);
    for (int k = 0; k < N; k++) req(k, 1'b1, 5'(k + 4), $urandom);
    cycle(1'b0);
    drain();

    // Hold freezes grants, pointer and counter
    for (int k = 0; k < N; k++) req(k, 1'b1, 5'(k + 7), $urandom);
    repeat (3) cycle(1'b1);
    repeat (3) cycle(1'b0);
    drain();

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      rand_reqs(60);
      cycle($urandom_range(0, 9) == 0);
    end
    drain();

    // Counter saturation under sustained contention
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < N; k++) req(k, 1'b1, 5'(k + 10), $urandom);
      cycle(1'b0);
    end
    check("cnt_saturated", 64'(conflict_cnt), 64'(CNT_MAX));
    drain();

    // Load requester every other cycle, others always valid
    for (int i = 0; i < 12; i++) begin
      req(0, (i % 2) == 0, 5'd20, $urandom);
      req(1, 1'b1, 5'd21, $urandom);
      req(2, 1'b1, 5'd22, $urandom);
      cycle(1'b0);
    end

    // Mid-burst reset clears the write strobe without a clock edge
    rst_n = 1'b0;
    #1;
    check("async_reg_write", 64'(reg_write), 64'd0);
    check("async_ready", 64'(req_ready), 64'd0);
    check("async_cnt", 64'(conflict_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    for (int k = 0; k < N; k++) req(k, 1'b1, 5'(k + 25), $urandom);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rand_reqs(70);
      cycle(1'b0);
    end
    for (int k = 0; k < N; k++) req(k, 1'b0, 5'd0, 32'd0);
    cycle(1'b0);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
